// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), optional two's-complement input via BCD_SIGNED_EN.
// Latency: start accepted at edge k -> done pulse after edge k+BIN_W+1; one conversion per BIN_W+2 cycles.
// Backpressure: none; start is ignored while busy (no queuing), results held in bcd_out until next done.
module bin_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
`ifdef BCD_SIGNED_EN
    output logic                  sign,
`endif
    output logic [4*DIGITS-1:0]   bcd_out
);

    // Decimal digits needed to represent 2^w-1.
    function automatic int min_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int SW         = 4 * DIGITS;
    localparam int CW         = $clog2(BIN_W + 1);
    localparam int MIN_DIGITS = min_digits(BIN_W);

    generate
        if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
            $error("bin_bcd_seq: BIN_W must be in 4..32");
        end
        if (DIGITS < MIN_DIGITS) begin : g_bad_digits
            $error("bin_bcd_seq: DIGITS too small to hold 2^BIN_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     scr_q, scr_d;
    logic [BIN_W-1:0]  op_q, op_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic              done_q, done_d;
    logic [BIN_W-1:0]  operand_in;
    logic [SW-1:0]     corr;
    logic [SW+BIN_W-1:0] shifted;

`ifdef BCD_SIGNED_EN
    logic neg_q, neg_d;
    logic sign_q, sign_d;

    // Convert the magnitude; the most-negative value wraps to its own unsigned magnitude.
    always_comb begin
        operand_in = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
    end
`else
    // Unsigned operand is converted as-is.
    always_comb begin
        operand_in = bin_in;
    end
`endif

    // Add-3 correction on every scratch digit >= 5, then shift the whole {scratch, operand} left.
    always_comb begin
        corr = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                corr[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
        shifted = {corr, op_q} << 1;
    end

    // Next-state and datapath control for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scr_d   = scr_q;
        op_d    = op_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
`ifdef BCD_SIGNED_EN
        neg_d   = neg_q;
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = CW'(BIN_W);
                    scr_d   = '0;
                    op_d    = operand_in;
`ifdef BCD_SIGNED_EN
                    neg_d   = bin_in[BIN_W-1];
`endif
                end
            end
            S_SHIFT: begin
                scr_d = shifted[SW+BIN_W-1:BIN_W];
                op_d  = shifted[BIN_W-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = scr_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef BCD_SIGNED_EN
                sign_d  = neg_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            scr_q   <= '0;
            op_q    <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg_q   <= 1'b0;
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scr_q   <= scr_d;
            op_q    <= op_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
`ifdef BCD_SIGNED_EN
            neg_q   <= neg_d;
            sign_q  <= sign_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;
`ifdef BCD_SIGNED_EN
    assign sign    = sign_q;
`endif

endmodule

// File: doc/bin_bcd_seq.md
BIN_BCD_SEQ -- requirements
Module: bin_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 8: width of binary input; legal range 4..32.
REQ-002 Parameter DIGITS, default 3: number of BCD output digits; DIGITS*4 SHALL hold 2^BIN_W-1, else elaboration error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  conversion request, sampled on rising edge.
REQ-006 bin_in  input  BIN_W  binary operand, captured only when start is accepted.
REQ-007 busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
REQ-008 done  output  1  single-cycle pulse: bcd_out valid and updated.
REQ-009 bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0], hundreds in [11:8], and so on.
REQ-010 sign  output  1  present only when BCD_SIGNED_EN is defined (see Configuration).

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE; reset state is IDLE.
REQ-012 IDLE: start=1 SHALL be accepted, bin_in captured, BCD scratch register cleared, iteration counter loaded with BIN_W, next state SHIFT.
REQ-013 SHIFT: each cycle, first add 3 to every scratch digit >= 5, then shift the {scratch, operand} register left by 1; decrement counter.
REQ-014 SHIFT SHALL last exactly BIN_W cycles, then go to DONE.
REQ-015 DONE: bcd_out loaded from scratch; done=1 for this cycle only; next state IDLE.
REQ-016 Latency: start accepted at edge k -> done high in the cycle after edge k+BIN_W+1; throughput one conversion per BIN_W+2 cycles.
REQ-017 start while busy=1 (SHIFT or DONE) SHALL be ignored; no queuing.
REQ-018 start in the IDLE cycle directly following DONE SHALL be accepted normally.
REQ-019 bcd_out SHALL hold its last value until the next DONE; it SHALL NOT change during SHIFT.
REQ-020 Digit correction SHALL never produce a digit > 9 in bcd_out for any legal input.
REQ-021 bin_in changes after acceptance SHALL NOT affect the result in progress.
REQ-022 Unused upper digits SHALL read 0.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, bcd_out=0, counter=0, scratch=0 (sign=0 when present).
REQ-024 Reset asserted mid-conversion SHALL abort it with no done pulse; first start after release converts normally.
REQ-025 Reset deassertion SHALL be synchronous to clk by the integrating design; no start is accepted in the cycle rst_n rises.

Configuration
REQ-026 Macro BCD_SIGNED_EN defined: bin_in is two's complement; magnitude is converted (BIN_W iterations unchanged); sign output registered in DONE as 1 for negative input; most-negative value converts to its full magnitude.
REQ-027 Macro BCD_SIGNED_EN undefined: bin_in is unsigned, sign port absent, no sign logic.

Verification
REQ-028 BIN_W=8, unsigned: bin_in=255, start pulse -> done at 10th cycle after acceptance edge, bcd_out=0x255, busy high 9 cycles.
REQ-029 BIN_W=8: bin_in=0 -> bcd_out=0x000; bin_in=99 -> 0x099; bin_in=100 -> 0x100.
REQ-030 start held high continuously with bin_in=37 then 200 -> only IDLE-cycle starts accepted; results 0x037 then 0x200, no extra done pulses.
REQ-031 rst_n pulsed low at SHIFT cycle 4 of bin_in=173 -> outputs 0 immediately, no done; next start with 42 -> 0x042.
REQ-032 BCD_SIGNED_EN, BIN_W=8: bin_in=0x80 -> bcd_out=0x128, sign=1; bin_in=0xFF -> 0x001, sign=1; bin_in=0x7F -> 0x127, sign=0.
REQ-033 BIN_W=16, DIGITS=5: exhaustive sweep 0..65535 vs reference model; every done matches and no digit exceeds 9.
